usb_tx: RTL and testbench

- Full-speed (12 Mb/s) USB packet transmitter, clocked from clk48. It is the transmit counterpart of the usb receive path.
- It serializes a device-to-host packet onto the D+/D- pads: SYNC, PID, optional payload from the USB data buffer, CRC16, then EOP.
- It performs bit stuffing and NRZI encoding, and it owns the pad output enable while sending.
- It sits beside the usb receiver inside the usb module. It reads the shared 256-word USB data buffer through the module-side port while the usb module owns the buffer.

---
 rtl/usb_pkg.sv | 38 +++
 rtl/usb_crc16.sv | 37 +++
 rtl/usb_tx.sv | 224 ++++++++++++++++++++++
 tb/tb_usb_tx.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - shared USB constants, line encodings and transmitter state type
package usb_pkg;

    localparam logic [3:0] PID_ACK   = 4'h2;
    localparam logic [3:0] PID_NAK   = 4'hA;
    localparam logic [3:0] PID_STALL = 4'hE;
    localparam logic [3:0] PID_DATA0 = 4'h3;
    localparam logic [3:0] PID_DATA1 = 4'hB;

    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    // {p, n}
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    localparam int CLOCKS_PER_BIT_DEFAULT = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_DATA,
        ST_CRC,
        ST_EOP_SE0,
        ST_EOP_J
    } tx_state_e;

    function automatic logic [15:0] reflect16(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) begin
            r[i] = v[15-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/usb_crc16.sv
// rtl/usb_crc16.sv - serial USB CRC16 over LSB-first bits
module usb_crc16
    import usb_pkg::*;
(
    input  logic        clk48,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        enable,
    input  logic        bit_in,
    output logic [15:0] crc_out
);

    // Register is kept bit-reversed so crc_out[0] is the first CRC bit on the wire.
    localparam logic [15:0] POLY_REFL = reflect16(CRC16_POLY);

    logic [15:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clear) begin
            crc_d = CRC16_INIT;
        end else if (enable) begin
            crc_d = (crc_q >> 1) ^ ((bit_in ^ crc_q[0]) ? POLY_REFL : 16'h0000);
        end
    end

    always_ff @(posedge clk48 or negedge reset_n) begin
        if (!reset_n) begin
            crc_q <= CRC16_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_out = crc_q;

endmodule

// File: rtl/usb_tx.sv
// rtl/usb_tx.sv - full-speed USB packet serializer: SYNC, PID, payload, CRC16, EOP
module usb_tx
    import usb_pkg::*;
#(
    parameter int CLOCKS_PER_BIT       = CLOCKS_PER_BIT_DEFAULT,
    parameter int BUFFER_ADDRESS_WIDTH = 8,
    parameter int LENGTH_WIDTH         = 10
) (
    input  logic                            clk48,
    input  logic                            reset_n,
    input  logic                            start,
    input  logic [3:0]                      pid,
    input  logic [LENGTH_WIDTH-1:0]         data_length,
    output logic [BUFFER_ADDRESS_WIDTH-1:0] buffer_address,
    input  logic [31:0]                     buffer_read_value,
    output logic                            usb_d_p_out,
    output logic                            usb_d_n_out,
    output logic                            usb_oe,
    output logic                            busy,
    output logic                            done
);

    localparam int CW = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLOCKS_PER_BIT - 1);

    tx_state_e                      state_q, state_d, ns;
    logic [3:0]                     idx_q, idx_d, nidx;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic [2:0]                     ones_q, ones_d;
    logic [LENGTH_WIDTH-1:0]        bi_q, bi_d, bi_n, len_q, len_d;
    logic [LENGTH_WIDTH:0]          bi_inc, next_word_start;
    logic [3:0]                     pid_q, pid_d;
    logic [31:0]                    word_q, word_d, data_word;
    logic [BUFFER_ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic                           dp_q, dp_d, dn_q, dn_d;
    logic                           oe_q, oe_d, busy_q, busy_d, done_q, done_d;
    logic                           tick, new_word, nbit, crc_clear, crc_en;
    logic [7:0]                     pid_byte;
    logic [15:0]                    crc_out;

    assign tick     = (cnt_q == CNT_LAST);
    assign pid_byte = {~pid_q, pid_q};
    assign bi_inc   = {1'b0, bi_q} + 1'b1;

    // Position (state, bit index, byte index) of the next non-stuff bit.
    always_comb begin
        ns   = state_q;
        nidx = idx_q + 4'd1;
        bi_n = bi_q;
        case (state_q)
            ST_SYNC: if (idx_q == 4'd7) begin
                ns   = ST_PID;
                nidx = 4'd0;
            end
            ST_PID: if (idx_q == 4'd7) begin
                nidx = 4'd0;
                if (pid_q[1:0] == PID_DATA0[1:0]) begin
                    bi_n = '0;
                    ns   = (len_q == '0) ? ST_CRC : ST_DATA;
                end else begin
                    ns = ST_EOP_SE0;
                end
            end
            ST_DATA: if (idx_q == 4'd7) begin
                nidx = 4'd0;
                if (bi_inc == {1'b0, len_q}) begin
                    ns = ST_CRC;
                end else begin
                    bi_n = bi_inc[LENGTH_WIDTH-1:0];
                end
            end
            ST_CRC: if (idx_q == 4'd15) begin
                ns   = ST_EOP_SE0;
                nidx = 4'd0;
            end
            ST_EOP_SE0: if (idx_q == 4'd1) begin
                ns   = ST_EOP_J;
                nidx = 4'd0;
            end
            default: begin
                ns   = ST_IDLE;
                nidx = 4'd0;
            end
        endcase
    end

    // A fresh word is taken straight from the buffer port on its first bit.
    assign new_word        = (ns == ST_DATA) && (nidx == 4'd0) && (bi_n[1:0] == 2'b00);
    assign data_word       = new_word ? buffer_read_value : word_q;
    assign next_word_start = {1'b0, bi_n[LENGTH_WIDTH-1:2], 2'b00} + (LENGTH_WIDTH+1)'(4);

    always_comb begin
        nbit = 1'b0;
        case (ns)
            ST_SYNC: nbit = (nidx == 4'd7);
            ST_PID:  nbit = pid_byte[nidx[2:0]];
            ST_DATA: nbit = data_word[{bi_n[1:0], nidx[2:0]}];
            ST_CRC:  nbit = ~crc_out[nidx];
            default: nbit = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = tick ? '0 : cnt_q + 1'b1;
        ones_d    = ones_q;
        bi_d      = bi_q;
        len_d     = len_q;
        pid_d     = pid_q;
        word_d    = word_q;
        addr_d    = addr_q;
        dp_d      = dp_q;
        dn_d      = dn_q;
        oe_d      = oe_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        crc_clear = 1'b0;
        crc_en    = 1'b0;
        if (state_q == ST_IDLE) begin
            cnt_d = '0;
            if (start) begin
                state_d      = ST_SYNC;
                idx_d        = 4'd0;
                ones_d       = 3'd0;
                bi_d         = '0;
                len_d        = data_length;
                pid_d        = pid;
                addr_d       = '0;
                {dp_d, dn_d} = LINE_K;
                oe_d         = 1'b1;
                busy_d       = 1'b1;
                crc_clear    = 1'b1;
            end
        end else if (tick) begin
            if (ones_q == 3'd6 && (state_q inside {ST_SYNC, ST_PID, ST_DATA, ST_CRC})) begin
                dp_d   = ~dp_q;
                dn_d   = ~dn_q;
                ones_d = 3'd0;
            end else begin
                state_d = ns;
                idx_d   = nidx;
                bi_d    = bi_n;
                crc_en  = (ns == ST_DATA);
                case (ns)
                    ST_SYNC, ST_PID, ST_DATA, ST_CRC: begin
                        if (nbit) begin
                            ones_d = ones_q + 3'd1;
                        end else begin
                            ones_d = 3'd0;
                            dp_d   = ~dp_q;
                            dn_d   = ~dn_q;
                        end
                    end
                    ST_EOP_SE0: {dp_d, dn_d} = LINE_SE0;
                    ST_EOP_J:   {dp_d, dn_d} = LINE_J;
                    default: begin
                        {dp_d, dn_d} = LINE_J;
                        oe_d         = 1'b0;
                        busy_d       = 1'b0;
                        done_d       = 1'b1;
                    end
                endcase
                if (new_word) begin
                    word_d = buffer_read_value;
                    if (next_word_start < {1'b0, len_q}) begin
                        addr_d = BUFFER_ADDRESS_WIDTH'(bi_n[LENGTH_WIDTH-1:2] + 1'b1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk48 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= 4'd0;
            cnt_q   <= '0;
            ones_q  <= 3'd0;
            bi_q    <= '0;
            len_q   <= '0;
            pid_q   <= 4'd0;
            word_q  <= 32'd0;
            addr_q  <= '0;
            dp_q    <= 1'b1;
            dn_q    <= 1'b0;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            ones_q  <= ones_d;
            bi_q    <= bi_d;
            len_q   <= len_d;
            pid_q   <= pid_d;
            word_q  <= word_d;
            addr_q  <= addr_d;
            dp_q    <= dp_d;
            dn_q    <= dn_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    usb_crc16 u_crc (
        .clk48   (clk48),
        .reset_n (reset_n),
        .clear   (crc_clear),
        .enable  (crc_en),
        .bit_in  (nbit),
        .crc_out (crc_out)
    );

    assign buffer_address = addr_q;
    assign usb_d_p_out    = dp_q;
    assign usb_d_n_out    = dn_q;
    assign usb_oe         = oe_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_usb_tx.sv
// tb/tb_usb_tx.sv - scoreboard bench for usb_tx with an NRZI/destuffing receiver model
module tb_usb_tx;
    import usb_pkg::*;

    logic        clk48 = 1'b0;
    logic        reset_n;
    logic        start;
    logic [3:0]  pid;
    logic [9:0]  data_length;
    logic [7:0]  buffer_address;
    logic [31:0] buffer_read_value;
    logic        usb_d_p_out, usb_d_n_out, usb_oe, busy, done;

    logic [31:0] mem [256];
    logic [7:0]  exp_q [$];
    bit          rx_bits [$];

    int n_cmp = 0;
    int n_err = 0;
    int stuff_cnt, stuff_pos, oe_cycles, done_cnt, addr_changes, se0_bits, end_j;
    int timing_err, stuff_err;
    logic after_done;

    usb_tx dut (
        .clk48             (clk48),
        .reset_n           (reset_n),
        .start             (start),
        .pid               (pid),
        .data_length       (data_length),
        .buffer_address    (buffer_address),
        .buffer_read_value (buffer_read_value),
        .usb_d_p_out       (usb_d_p_out),
        .usb_d_n_out       (usb_d_n_out),
        .usb_oe            (usb_oe),
        .busy              (busy),
        .done              (done)
    );

    always #10 clk48 = ~clk48;

    always @(posedge clk48) buffer_read_value <= mem[buffer_address];

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    // Drives one packet, then decodes the line and checks bytes against the scoreboard.
    task automatic run_packet(input logic [3:0] p, input int len, input bit noise);
        logic [15:0] crc;
        logic [7:0]  b, e;
        logic [31:0] w;
        logic [1:0]  line, prev_line, bit_line;
        logic [7:0]  prev_addr;
        int          ones, nbytes;
        bit          bv, finished;
        exp_q.delete();
        rx_bits.delete();
        stuff_cnt = 0; stuff_pos = -1; oe_cycles = 0; done_cnt = 0; addr_changes = 0;
        se0_bits = 0; end_j = 0; timing_err = 0; stuff_err = 0;
        exp_q.push_back(8'h80);
        exp_q.push_back({~p, p});
        if (p[1:0] == 2'b11) begin
            crc = 16'hFFFF;
            for (int i = 0; i < len; i++) begin
                w = mem[i/4];
                b = w[(i%4)*8 +: 8];
                exp_q.push_back(b);
                for (int k = 0; k < 8; k++)
                    crc = {crc[14:0], 1'b0} ^ ((b[k] ^ crc[15]) ? 16'h8005 : 16'h0000);
            end
            crc = ~crc;
            exp_q.push_back(rev8(crc[15:8]));
            exp_q.push_back(rev8(crc[7:0]));
        end
        @(negedge clk48);
        start = 1'b1; pid = p; data_length = len[9:0];
        @(negedge clk48);
        start = 1'b0; pid = 4'h0; data_length = 10'd0;
        n_cmp++;
        if ({busy, usb_oe, usb_d_p_out, usb_d_n_out} !== 4'b1101) begin
            n_err++;
            $display("FAIL accept: busy/oe/p/n got %b want 1101", {busy, usb_oe, usb_d_p_out, usb_d_n_out});
        end
        prev_line = LINE_K;
        bit_line  = LINE_J;
        prev_addr = buffer_address;
        ones      = 0;
        finished  = 0;
        for (int c = 0; c < 40000; c++) begin
            if (c > 0) @(negedge clk48);
            line = {usb_d_p_out, usb_d_n_out};
            if (usb_oe === 1'b1) oe_cycles++;
            if (buffer_address !== prev_addr) begin
                addr_changes++;
                prev_addr = buffer_address;
            end
            if (c > 0 && line !== prev_line && (c % 4) != 0) timing_err++;
            prev_line = line;
            if (done === 1'b1) begin
                done_cnt++;
                start    = 1'b0;
                finished = 1;
                break;
            end
            if (noise) begin
                start = ((c % 64) == 32);
                pid   = PID_ACK;
            end
            if ((c % 4) == 2 && usb_oe === 1'b1) begin
                if (line == LINE_SE0) begin
                    se0_bits++;
                end else if (se0_bits > 0) begin
                    if (line == LINE_J) end_j++;
                end else begin
                    bv = (line == bit_line);
                    bit_line = line;
                    if (ones == 6) begin
                        stuff_cnt++;
                        if (stuff_pos < 0) stuff_pos = rx_bits.size();
                        if (bv) stuff_err++;
                        ones = 0;
                    end else begin
                        rx_bits.push_back(bv);
                        ones = bv ? ones + 1 : 0;
                    end
                end
            end
        end
        start = 1'b0;
        n_cmp++;
        if (!finished) begin
            n_err++;
            $display("FAIL timeout: done not seen within 40000 cycles");
        end
        @(negedge clk48);
        after_done = done;
        n_cmp++;
        if (rx_bits.size() != exp_q.size() * 8) begin
            n_err++;
            $display("FAIL bitcount: got %0d want %0d", rx_bits.size(), exp_q.size() * 8);
        end
        nbytes = rx_bits.size() / 8;
        for (int i = 0; i < nbytes && exp_q.size() > 0; i++) begin
            for (int k = 0; k < 8; k++) b[k] = rx_bits[i*8 + k];
            e = exp_q.pop_front();
            n_cmp++;
            if (b !== e) begin
                n_err++;
                $display("FAIL byte[%0d]: got %02h want %02h", i, b, e);
            end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge clk48);
        n_cmp++;
        if ({usb_oe, usb_d_p_out, usb_d_n_out, busy, done} !== 5'b01000) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want 01000", {usb_oe, usb_d_p_out, usb_d_n_out, busy, done});
        end
        n_cmp++;
        if (buffer_address !== 8'd0) begin
            n_err++;
            $display("FAIL reset_addr: got %0d want 0", buffer_address);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk48);
        n_cmp++;
        if ({usb_oe, busy, done} !== 3'b000) begin
            n_err++;
            $display("FAIL idle_after_reset: got %b want 000", {usb_oe, busy, done});
        end
    endtask

    task automatic test_ack;
        run_packet(PID_ACK, 0, 0);
        n_cmp++;
        if (oe_cycles != 76) begin n_err++; $display("FAIL ack_oe_cycles: got %0d want 76", oe_cycles); end
        n_cmp++;
        if (done_cnt != 1 || after_done !== 1'b0) begin
            n_err++; $display("FAIL ack_done: got count %0d after %b want 1 and 0", done_cnt, after_done);
        end
        n_cmp++;
        if (stuff_cnt != 0) begin n_err++; $display("FAIL ack_stuff: got %0d want 0", stuff_cnt); end
        n_cmp++;
        if (se0_bits != 2 || end_j != 1) begin
            n_err++; $display("FAIL ack_eop: got se0 %0d j %0d want 2 1", se0_bits, end_j);
        end
        n_cmp++;
        if (timing_err != 0) begin n_err++; $display("FAIL ack_bit_timing: got %0d want 0", timing_err); end
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL ack_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_data0_empty;
        run_packet(PID_DATA0, 0, 0);
        n_cmp++;
        if (oe_cycles != 140) begin n_err++; $display("FAIL empty_oe_cycles: got %0d want 140", oe_cycles); end
        n_cmp++;
        if (addr_changes != 0) begin n_err++; $display("FAIL empty_reads: got %0d want 0", addr_changes); end
    endtask

    task automatic test_data1_len4;
        mem[0] = 32'h04030201;
        run_packet(PID_DATA1, 4, 0);
        n_cmp++;
        if (addr_changes != 0 || buffer_address !== 8'd0) begin
            n_err++; $display("FAIL len4_addr: got changes %0d addr %0d want 0 0", addr_changes, buffer_address);
        end
        n_cmp++;
        if (timing_err != 0 || stuff_err != 0) begin
            n_err++; $display("FAIL len4_line: got timing %0d stuff %0d want 0 0", timing_err, stuff_err);
        end
    endtask

    task automatic test_data0_ff;
        logic [15:0] res;
        mem[0] = 32'h000000FF;
        run_packet(PID_DATA0, 1, 0);
        n_cmp++;
        if (stuff_pos != 20) begin n_err++; $display("FAIL ff_stuff_pos: got %0d want 20", stuff_pos); end
        n_cmp++;
        if (stuff_err != 0) begin n_err++; $display("FAIL ff_stuff_toggle: got %0d want 0", stuff_err); end
        res = 16'hFFFF;
        for (int i = 16; i < rx_bits.size(); i++)
            res = {res[14:0], 1'b0} ^ ((rx_bits[i] ^ res[15]) ? 16'h8005 : 16'h0000);
        n_cmp++;
        if (res !== 16'h800D) begin n_err++; $display("FAIL ff_crc_residual: got %04h want 800d", res); end
    endtask

    task automatic test_long;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        run_packet(PID_DATA0, 1023, 1);
        pid = 4'h0;
        n_cmp++;
        if (addr_changes != 255 || buffer_address !== 8'd255) begin
            n_err++; $display("FAIL long_addr: got changes %0d addr %0d want 255 255", addr_changes, buffer_address);
        end
        n_cmp++;
        if (done_cnt != 1 || timing_err != 0) begin
            n_err++; $display("FAIL long_done_timing: got done %0d timing %0d want 1 0", done_cnt, timing_err);
        end
        repeat (8) @(negedge clk48);
        n_cmp++;
        if ({busy, usb_oe} !== 2'b00) begin
            n_err++; $display("FAIL long_no_restart: got busy/oe %b want 00", {busy, usb_oe});
        end
    endtask

    task automatic test_reset_mid;
        logic seen_done;
        mem[0] = 32'hA5A5A5A5;
        mem[1] = 32'h5A5A5A5A;
        @(negedge clk48);
        start = 1'b1; pid = PID_DATA1; data_length = 10'd8;
        @(negedge clk48);
        start = 1'b0;
        repeat (100) @(negedge clk48);
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL midreset_running: got busy %b want 1", busy); end
        #3 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({usb_d_p_out, usb_d_n_out, usb_oe, busy, done} !== 5'b10000) begin
            n_err++;
            $display("FAIL midreset_outputs: got %b want 10000", {usb_d_p_out, usb_d_n_out, usb_oe, busy, done});
        end
        seen_done = 1'b0;
        repeat (3) begin
            @(negedge clk48);
            if (done !== 1'b0) seen_done = 1'b1;
        end
        reset_n = 1'b1;
        repeat (4) begin
            @(negedge clk48);
            if (done !== 1'b0) seen_done = 1'b1;
        end
        n_cmp++;
        if (seen_done !== 1'b0) begin n_err++; $display("FAIL midreset_done: got %b want 0", seen_done); end
        run_packet(PID_ACK, 0, 0);
        n_cmp++;
        if (oe_cycles != 76 || done_cnt != 1) begin
            n_err++; $display("FAIL post_reset_ack: got oe %0d done %0d want 76 1", oe_cycles, done_cnt);
        end
    endtask

    initial begin
        start = 1'b0;
        pid = 4'h0;
        data_length = 10'd0;
        reset_n = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        test_reset();
        test_ack();
        test_data0_empty();
        test_data1_len4();
        test_data0_ff();
        test_long();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
